// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the clock frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-second gate window at a 50 MHz system clock.
  localparam int DEFAULT_GATE_CYCLES = 50_000_000;

  // Width of the gate down-counter; it only ever holds GATE_CYCLES-1 .. 0.
  function automatic int gate_cnt_w(input int gate_cycles);
    return (gate_cycles <= 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk domain and flags its rising edges.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;

endmodule

// File: rtl/clock_freq_meter.sv
// Counts rising edges of an asynchronous clock over a fixed window of system clocks
// and reports the count once per window.
module clock_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq_out,
  output logic             overflow
);

  localparam int               GCW       = gate_cnt_w(GATE_CYCLES);
  localparam logic [GCW-1:0]   GATE_LOAD = GCW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q;
  logic [GCW-1:0]   gate_q;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] freq_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;
  logic             rise;
  logic             meas_sync_unused;
  logic             rise_hit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(meas_clk),
    .sync_out(meas_sync_unused),
    .rise    (rise)
  );

  // Edges outside GATE are dropped; the counter sticks at max and flags the lost edge.
  always_comb begin
    rise_hit = (state_q == GATE) && rise;
    edge_d   = edge_q;
    ovf_d    = ovf_q;
    if (rise_hit) begin
      if (edge_q == CNT_MAX) ovf_d = 1'b1;
      else                   edge_d = edge_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CONTINUOUS || start) begin
            state_q <= GATE;
            gate_q  <= GATE_LOAD;
            edge_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        GATE: begin
          edge_q <= edge_d;
          ovf_q  <= ovf_d;
          if (gate_q == '0) begin
            // Last counted cycle: publish including any edge seen right now.
            state_q    <= DONE;
            freq_q     <= edge_d;
            overflow_q <= ovf_d;
            done_q     <= 1'b1;
          end else begin
            gate_q <= gate_q - 1'b1;
          end
        end
        DONE: begin
          if (CONTINUOUS) begin
            state_q <= GATE;
            gate_q  <= GATE_LOAD;
            edge_q  <= '0;
            ovf_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign freq_out = freq_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_clock_freq_meter.sv
// Directed bench for clock_freq_meter: one-shot, saturating and continuous instances.
module tb_clock_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ma, mb, mc;
  logic       sa, sb, sc;
  logic       busy_a, done_a, ovf_a;
  logic       busy_b, done_b, ovf_b;
  logic       busy_c, done_c, ovf_c;
  logic [7:0] freq_a, freq_c;
  logic [3:0] freq_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Per-instance meas_clk shape: mode 0 = stuck low, 1 = stuck high, 2 = clock.
  int mode_a = 2, per_a = 10, org_a = 0;
  int mode_b = 2, per_b = 10, org_b = 0;
  int mode_c = 2, per_c = 5,  org_c = 0;

  clock_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2), .CONTINUOUS(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .meas_clk(ma), .start(sa),
    .busy(busy_a), .done(done_a), .freq_out(freq_a), .overflow(ovf_a));

  clock_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2), .CONTINUOUS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .meas_clk(mb), .start(sb),
    .busy(busy_b), .done(done_b), .freq_out(freq_b), .overflow(ovf_b));

  clock_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2), .CONTINUOUS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .meas_clk(mc), .start(sc),
    .busy(busy_c), .done(done_c), .freq_out(freq_c), .overflow(ovf_c));

  function automatic logic wave(input int mode, input int per, input int org, input int c);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    if (c < org) return 1'b0;
    return ((c - org) % per) < (per / 2);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    ma = wave(mode_a, per_a, org_a, cyc);
    mb = wave(mode_b, per_b, org_b, cyc);
    mc = wave(mode_c, per_c, org_c, cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one window on instance a (sel 0) or b (sel 1); n = cycles from start cycle to done.
  task automatic measure(input int sel, input int mode, input int per, input bit pulse_mid,
                         output int n);
    if (sel == 0) begin mode_a = mode; per_a = per; org_a = cyc + 10; end
    else          begin mode_b = mode; per_b = per; org_b = cyc + 10; end
    repeat (4) tick();
    if (sel == 0) sa = 1'b1; else sb = 1'b1;
    n = 0;
    while (!((sel == 0) ? done_a : done_b) && n < 300) begin
      tick();
      n++;
      if (n == 1) chk("busy_rise", (sel == 0) ? busy_a : busy_b, 1);
      sa = (sel == 0) && pulse_mid && (n == 50);
      sb = 1'b0;
    end
  endtask

  int n;
  int cnt_done, cnt_busy;
  bit busy_ok;

  initial begin
    rst_n = 1'b0;
    sa = 1'b0; sb = 1'b0; sc = 1'b0;
    ma = 1'b0; mb = 1'b0; mc = 1'b0;
    repeat (5) tick();
    chk("rst_a", {busy_a, done_a, freq_a, ovf_a}, 0);
    chk("rst_b", {busy_b, done_b, freq_b, ovf_b}, 0);
    chk("rst_c", {busy_c, done_c, freq_c, ovf_c}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_after_rst", {busy_a, done_a, freq_a, ovf_a}, 0);
    end

    // One-shot, period 10 -> 10 edges in 100 cycles
    measure(0, 2, 10, 1'b0, n);
    chk("oneshot_latency", n, 101);
    chk("oneshot_freq", freq_a, 10);
    chk("oneshot_ovf", ovf_a, 0);
    chk("oneshot_busy_in_done", busy_a, 1);
    tick();
    chk("oneshot_done_pulse", done_a, 0);
    chk("oneshot_busy_fall", busy_a, 0);
    repeat (5) tick();
    chk("oneshot_freq_hold", freq_a, 10);

    // Stuck low, then stuck high
    measure(0, 0, 10, 1'b0, n);
    chk("stuck0_latency", n, 101);
    chk("stuck0_freq", freq_a, 0);
    chk("stuck0_ovf", ovf_a, 0);
    tick();
    measure(0, 1, 10, 1'b0, n);
    chk("stuck1_latency", n, 101);
    chk("stuck1_freq", freq_a, 0);
    tick();

    // Saturation on the 4-bit instance, then recovery
    measure(1, 2, 4, 1'b0, n);
    chk("sat_latency", n, 101);
    chk("sat_freq", freq_b, 15);
    chk("sat_ovf", ovf_b, 1);
    tick();
    measure(1, 2, 10, 1'b0, n);
    chk("sat_recover_freq", freq_b, 10);
    chk("sat_recover_ovf", ovf_b, 0);
    tick();

    // Second start mid-window is ignored
    measure(0, 2, 10, 1'b1, n);
    chk("ignore_latency", n, 101);
    chk("ignore_freq", freq_a, 10);
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (done_a) cnt_done++;
      if (busy_a) cnt_busy++;
    end
    chk("ignore_no_second_done", cnt_done, 0);
    chk("ignore_no_second_busy", cnt_busy, 0);

    // Reset 40 cycles into a window
    sa = 1'b1;
    tick();
    sa = 1'b0;
    repeat (39) tick();
    chk("midrst_busy_before", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy_a, done_a, freq_a, ovf_a}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done_a) cnt_done++;
    end
    chk("midrst_no_done", cnt_done, 0);
    chk("midrst_freq_zero", freq_a, 0);
    measure(0, 2, 10, 1'b0, n);
    chk("midrst_new_latency", n, 101);
    chk("midrst_new_freq", freq_a, 10);
    chk("midrst_new_ovf", ovf_a, 0);

    // Continuous instance, period 5: a result every 101 cycles, busy never drops
    n = 0;
    while (!done_c && n < 300) begin
      tick();
      n++;
    end
    chk("cont_first_done", done_c, 1);
    for (int w = 0; w < 3; w++) begin
      n = 0;
      busy_ok = 1'b1;
      do begin
        tick();
        n++;
        if (!busy_c) busy_ok = 1'b0;
      end while (!done_c && n < 300);
      chk("cont_period", n, 101);
      chk("cont_freq", freq_c, 20);
      chk("cont_ovf", ovf_c, 0);
      chk("cont_busy", busy_ok, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
